// File: rtl/boot_memory_pkg.sv
// -----------------------------------------------------------------------------
// boot_memory_pkg
// Shared definitions for the self-loading boot memory:
//   - SPI flash READ opcode and the command/address field widths
//   - load sequencer state encoding
//   - helper that picks one byte of the 24-bit flash start address
// -----------------------------------------------------------------------------
package boot_memory_pkg;

  localparam logic [7:0] SPI_CMD_READ = 8'h03;
  localparam int         CMD_BITS     = 8;
  localparam int         ADDR_BITS    = 24;
  localparam int         ADDR_BYTES   = ADDR_BITS / 8;

  typedef enum logic [2:0] {
    S_START,
    S_CMD,
    S_ADDR,
    S_READ,
    S_ZERO,
    S_DONE
  } boot_state_e;

  // Address bytes go out MSB first: index 0 is bits [23:16].
  function automatic logic [7:0] flash_addr_byte(input logic [23:0] base,
                                                 input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = base[23:16];
      2'd1:    b = base[15:8];
      default: b = base[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/boot_memory_spi_shift8.sv
// -----------------------------------------------------------------------------
// spi_shift8
// One-byte SPI mode-0 shifter running at clk/2. A byte takes 16 clk cycles:
// each bit is a low half (mosi settles) followed by a high half (miso is
// captured on the edge that raises sclk). done_o is high during the final
// high half; a start_i seen in that cycle reloads the shifter without a gap,
// so back-to-back bytes keep a steady 2-clk bit period.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start_i     load tx_i and begin a byte (accepted when idle or on done_o)
//   tx_i        byte to transmit, MSB first
//   miso_i      serial data from the flash
//   busy_o      byte in flight
//   rx_o        received byte, complete while done_o is high
//   done_o      last cycle of the current byte
//   sclk_o      SPI clock, idles low
//   mosi_o      serial data to the flash, low when idle
// -----------------------------------------------------------------------------
module spi_shift8
  import boot_memory_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] tx_i,
  input  logic       miso_i,
  output logic       busy_o,
  output logic [7:0] rx_o,
  output logic       done_o,
  output logic       sclk_o,
  output logic       mosi_o
);

  localparam logic [2:0] BIT_LAST = 3'(CMD_BITS - 1);

  logic       busy_q, busy_d;
  logic       sclk_q, sclk_d;
  logic [2:0] cnt_q,  cnt_d;
  logic [7:0] tx_q,   tx_d;
  logic [7:0] rx_q,   rx_d;
  logic       load;

  assign done_o = busy_q & sclk_q & (cnt_q == 3'd0);
  assign load   = start_i & (~busy_q | done_o);

  always_comb begin
    busy_d = busy_q;
    sclk_d = sclk_q;
    cnt_d  = cnt_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    if (load) begin
      busy_d = 1'b1;
      sclk_d = 1'b0;
      cnt_d  = BIT_LAST;
      tx_d   = tx_i;
    end else if (busy_q) begin
      if (!sclk_q) begin
        // Rising sclk: capture the flash bit.
        sclk_d = 1'b1;
        rx_d   = {rx_q[6:0], miso_i};
      end else begin
        // Falling sclk: present the next bit, or finish the byte.
        sclk_d = 1'b0;
        if (cnt_q == 3'd0) begin
          busy_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 3'd1;
          tx_d  = {tx_q[6:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      sclk_q <= 1'b0;
      cnt_q  <= 3'd0;
    end else begin
      busy_q <= busy_d;
      sclk_q <= sclk_d;
      cnt_q  <= cnt_d;
    end
  end

  // Shift registers carry data only; busy gates their visibility.
  always_ff @(posedge clk) begin
    tx_q <= tx_d;
    rx_q <= rx_d;
  end

  assign busy_o = busy_q;
  assign rx_o   = rx_q;
  assign sclk_o = sclk_q;
  assign mosi_o = busy_q & tx_q[7];

endmodule

// File: rtl/boot_memory.sv
// -----------------------------------------------------------------------------
// boot_memory
// Boot memory that copies its image from SPI flash after reset, then serves
// the CPU as a ROM (or RAM when WRITABLE=1). ready holds the CPU off until the
// image, plus zero fill of the words above LOAD_WORDS, is in place.
//
// Parameters:
//   ADDR_W      word address width, depth = 2**ADDR_W
//   DATA_W      word width, multiple of 8 in 8..32
//   LOAD_WORDS  words copied from flash, 1..2**ADDR_W
//   FLASH_BASE  flash byte address of the image
//   WRITABLE    1 enables CPU writes once ready
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   addr        CPU word address, registered every cycle
//   data        mem[registered addr], combinational
//   we, wdata   CPU write strobe and data
//   ready       image loaded
//   spi_*       mode-0 flash interface, sclk = clk/2
// -----------------------------------------------------------------------------
module boot_memory
  import boot_memory_pkg::*;
#(
  parameter int          ADDR_W     = 11,
  parameter int          DATA_W     = 8,
  parameter int          LOAD_WORDS = 2 ** ADDR_W,
  parameter logic [23:0] FLASH_BASE = 24'h100000,
  parameter int          WRITABLE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int              DEPTH      = 2 ** ADDR_W;
  localparam int              BYTES      = DATA_W / 8;
  localparam logic [ADDR_W:0] LOAD_LAST  = (ADDR_W + 1)'(LOAD_WORDS - 1);
  localparam logic [ADDR_W:0] DEPTH_LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [1:0]      BYTE_LAST  = 2'(BYTES - 1);
  localparam logic [1:0]      ADDR_LAST  = 2'(ADDR_BYTES - 1);
  localparam bit              NEED_ZERO  = (LOAD_WORDS < DEPTH);
  localparam bit              WR_EN      = (WRITABLE != 0);

  boot_state_e       state_q, state_d;
  logic [ADDR_W:0]   cnt_q,   cnt_d;    // word index for load and zero fill
  logic [1:0]        bcnt_q,  bcnt_d;   // byte index within address / word
  logic              cs_n_q,  cs_n_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] wbuf_q,  wbuf_d;   // partially assembled word
  logic [ADDR_W-1:0] addr_q;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              sh_start;
  logic [7:0]        sh_tx;
  logic              sh_busy;
  logic [7:0]        sh_rx;
  logic              sh_done;
  logic              sh_sclk;
  logic              sh_mosi;

  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] word_next;
  logic              cpu_we;

  spi_shift8 u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (sh_start),
    .tx_i    (sh_tx),
    .miso_i  (spi_miso),
    .busy_o  (sh_busy),
    .rx_o    (sh_rx),
    .done_o  (sh_done),
    .sclk_o  (sh_sclk),
    .mosi_o  (sh_mosi)
  );

  // Little-endian assembly: each new byte enters at the top and older bytes
  // slide down, so after BYTES bytes the first one sits in [7:0].
  always_comb begin
    word_next = wbuf_q >> 8;
    word_next[DATA_W-1 -: 8] = sh_rx;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bcnt_d   = bcnt_q;
    cs_n_d   = cs_n_q;
    wbuf_d   = wbuf_q;
    ready_d  = (state_q == S_DONE);
    sh_start = 1'b0;
    sh_tx    = 8'h00;
    ld_we    = 1'b0;
    ld_addr  = cnt_q[ADDR_W-1:0];
    ld_data  = word_next;

    case (state_q)
      S_START: begin
        if (!sh_busy) begin
          cs_n_d   = 1'b0;
          sh_start = 1'b1;
          sh_tx    = SPI_CMD_READ;
          cnt_d    = '0;
          bcnt_d   = 2'd0;
          state_d  = S_CMD;
        end
      end

      S_CMD: begin
        if (sh_done) begin
          sh_start = 1'b1;
          sh_tx    = flash_addr_byte(FLASH_BASE, 2'd0);
          bcnt_d   = 2'd0;
          state_d  = S_ADDR;
        end
      end

      S_ADDR: begin
        if (sh_done) begin
          sh_start = 1'b1;
          if (bcnt_q == ADDR_LAST) begin
            bcnt_d  = 2'd0;
            state_d = S_READ;
          end else begin
            sh_tx  = flash_addr_byte(FLASH_BASE, bcnt_q + 2'd1);
            bcnt_d = bcnt_q + 2'd1;
          end
        end
      end

      S_READ: begin
        if (sh_done) begin
          wbuf_d = word_next;
          if (bcnt_q == BYTE_LAST) begin
            ld_we  = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            bcnt_d = 2'd0;
            if (cnt_q == LOAD_LAST) begin
              // Last bit of the image: release the flash with this write.
              cs_n_d  = 1'b1;
              state_d = NEED_ZERO ? S_ZERO : S_DONE;
            end else begin
              sh_start = 1'b1;
            end
          end else begin
            bcnt_d   = bcnt_q + 2'd1;
            sh_start = 1'b1;
          end
        end
      end

      S_ZERO: begin
        ld_we   = 1'b1;
        ld_data = '0;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == DEPTH_LAST) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
      end

      default: begin
        state_d = S_START;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_START;
      cnt_q   <= '0;
      bcnt_q  <= 2'd0;
      cs_n_q  <= 1'b1;
      ready_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      cs_n_q  <= cs_n_d;
      ready_q <= ready_d;
      addr_q  <= addr;
    end
  end

  always_ff @(posedge clk) begin
    wbuf_q <= wbuf_d;
  end

  // Load writes only happen while ready is low and CPU writes only while it
  // is high, so the two write sources never collide.
  assign cpu_we = WR_EN & ready_q & we;

  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem_q[ld_addr] <= ld_data;
    end else if (cpu_we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign data     = mem_q[addr_q];
  assign ready    = ready_q;
  assign spi_cs_n = cs_n_q;
  assign spi_sclk = sh_sclk;
  assign spi_mosi = sh_mosi;

endmodule

// File: tb/tb_boot_memory.sv
module tb_boot_memory;

  localparam logic [23:0] A_BASE = 24'h100000;
  localparam logic [23:0] B_BASE = 24'h000040;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters (2K x 8 ROM)
  logic        rst_a;
  logic [10:0] addr_a;
  logic [7:0]  data_a, wdata_a;
  logic        we_a, ready_a, cs_a, sclk_a, mosi_a;
  logic        miso_a = 1'b0;

  // Instance B: 8 x 16 RAM, 4 words from flash
  logic        rst_b;
  logic [2:0]  addr_b;
  logic [15:0] data_b, wdata_b;
  logic        we_b, ready_b, cs_b, sclk_b, mosi_b;
  logic        miso_b = 1'b0;

  boot_memory u_a (
    .clk(clk), .rst_n(rst_a), .addr(addr_a), .data(data_a), .we(we_a),
    .wdata(wdata_a), .ready(ready_a), .spi_cs_n(cs_a), .spi_sclk(sclk_a),
    .spi_mosi(mosi_a), .spi_miso(miso_a)
  );

  boot_memory #(
    .ADDR_W(3), .DATA_W(16), .LOAD_WORDS(4), .FLASH_BASE(B_BASE), .WRITABLE(1)
  ) u_b (
    .clk(clk), .rst_n(rst_b), .addr(addr_b), .data(data_b), .we(we_b),
    .wdata(wdata_b), .ready(ready_b), .spi_cs_n(cs_b), .spi_sclk(sclk_b),
    .spi_mosi(mosi_b), .spi_miso(miso_b)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural SPI flash (one per instance) ----------------
  logic [7:0]  fb [16];
  longint      cyc = 0;
  int          bitc [2]      = '{0, 0};
  logic [31:0] cmdsh [2]     = '{32'h0, 32'h0};
  logic [31:0] cmd_last [2]  = '{32'h0, 32'h0};
  int          trans [2]     = '{0, 0};
  int          dbits [2]     = '{0, 0};
  int          tim_err [2]   = '{0, 0};
  logic        prev_sclk [2] = '{1'b0, 1'b0};
  longint      last_rise [2] = '{0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] flash_byte(input int d, input logic [23:0] a);
    logic [23:0] off;
    if (d == 0) begin
      off = a - A_BASE;
      return off[7:0];
    end
    off = a - B_BASE;
    if (off < 24'd16) return fb[off[3:0]];
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      logic cs, sc, mo;
      int j;
      logic [7:0] fbyte;
      cs = (d == 0) ? cs_a   : cs_b;
      sc = (d == 0) ? sclk_a : sclk_b;
      mo = (d == 0) ? mosi_a : mosi_b;
      if (cs) begin
        bitc[d] = 0;
      end else if (!prev_sclk[d] && sc) begin
        if (bitc[d] > 0 && (cyc - last_rise[d]) != 2) tim_err[d]++;
        last_rise[d] = cyc;
        if (bitc[d] < 32) begin
          cmdsh[d] = {cmdsh[d][30:0], mo};
          if (bitc[d] == 31) begin
            cmd_last[d] = cmdsh[d];
            trans[d]++;
            dbits[d] = 0;
          end
        end else begin
          dbits[d]++;
        end
        bitc[d]++;
      end else if (prev_sclk[d] && !sc && bitc[d] >= 32) begin
        j = bitc[d] - 32;
        fbyte = flash_byte(d, cmd_last[d][23:0] + 24'(j / 8));
        if (d == 0) miso_a = fbyte[7 - (j % 8)];
        else        miso_b = fbyte[7 - (j % 8)];
      end
      prev_sclk[d] = sc;
    end
  end

  // ------------------------------- stimulus ---------------------------------
  logic [15:0] mb [8];
  int          n;
  int          xcnt;
  bit          first;

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    addr_a = '0; we_a = 1'b0; wdata_a = '0;
    addr_b = '0; we_b = 1'b0; wdata_b = '0;
    xcnt = 0;
    repeat (3) tick();

    chk("a_rst_cs_n",  cs_a,    1'b1);
    chk("a_rst_sclk",  sclk_a,  1'b0);
    chk("a_rst_mosi",  mosi_a,  1'b0);
    chk("a_rst_ready", ready_a, 1'b0);
    chk("b_rst_cs_n",  cs_b,    1'b1);
    chk("b_rst_sclk",  sclk_b,  1'b0);
    chk("b_rst_mosi",  mosi_b,  1'b0);
    chk("b_rst_ready", ready_b, 1'b0);

    // ---- instance B: fixed image first, then a random one ----
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 16; i++)
        fb[i] = (p == 0) ? 8'((i + 1) * 17) : 8'($urandom);
      for (int i = 0; i < 8; i++)
        mb[i] = (i < 4) ? {fb[2*i+1], fb[2*i]} : 16'h0000;
      // A write to word 0 held throughout the load must be dropped.
      addr_b = 3'd0; we_b = 1'b1; wdata_b = ~mb[0];
      @(negedge clk); rst_b = 1'b1;
      n = 0;
      while (!ready_b && n < 1000) begin
        tick();
        n++;
        if ($isunknown({cs_b, sclk_b, mosi_b})) xcnt++;
      end
      we_b = 1'b0;
      chk("b_ready", ready_b, 1'b1);
      chk("b_ready_lat", (n >= 197 && n <= 199) ? 198 : n, 198);
      chk("b_cs_n_after_load", cs_b, 1'b1);
      chk("b_cmd", cmd_last[1], {8'h03, B_BASE});
      chk("b_data_bits", dbits[1], 64);
      chk("b_bit_timing", tim_err[1], 0);
      for (int i = 0; i < 8; i++) begin
        addr_b = 3'(i);
        tick();
        chk($sformatf("b_word%0d", i), data_b, mb[i]);
      end
      for (int k = 0; k < 6; k++) begin
        logic [2:0]  r;
        logic [15:0] w;
        r = 3'($urandom);
        w = 16'($urandom);
        addr_b = r; we_b = 1'b1; wdata_b = w;
        tick();
        we_b = 1'b0;
        mb[r] = w;
        chk("b_wr_rd", data_b, w);
      end
      for (int i = 0; i < 8; i++) begin
        addr_b = 3'(i);
        tick();
        chk($sformatf("b_post_wr%0d", i), data_b, mb[i]);
      end
      #1 rst_b = 1'b0;
      #1;
      chk("b_async_cs_n",  cs_b,    1'b1);
      chk("b_async_ready", ready_b, 1'b0);
      tick();
    end

    // ---- instance A: full default load, interrupted by reset at cycle 500 ----
    @(negedge clk); rst_a = 1'b1;
    first = 1'b1;
    n = 0;
    while (!ready_a && n < 40000) begin
      addr_a = 11'($urandom); we_a = 1'($urandom); wdata_a = 8'($urandom);
      tick();
      n++;
      if ($isunknown({cs_a, sclk_a, mosi_a})) xcnt++;
      if (first && n == 500) begin
        #1 rst_a = 1'b0;
        #1;
        chk("a_async_cs_n",  cs_a,    1'b1);
        chk("a_async_ready", ready_a, 1'b0);
        chk("a_async_sclk",  sclk_a,  1'b0);
        repeat (4) tick();
        chk("a_trans1", trans[0], 1);
        chk("a_cmd1", cmd_last[0], 32'h03100000);
        @(negedge clk); rst_a = 1'b1;
        n = 0;
        first = 1'b0;
      end
    end
    we_a = 1'b0;
    chk("a_ready", ready_a, 1'b1);
    chk("a_ready_lat", (n >= 32833 && n <= 32835) ? 32834 : n, 32834);
    chk("a_trans2", trans[0], 2);
    chk("a_cmd2", cmd_last[0], 32'h03100000);
    chk("a_data_bits", dbits[0], 16384);
    chk("a_bit_timing", tim_err[0], 0);
    chk("a_no_x", xcnt, 0);

    addr_a = 11'h005;
    tick();
    chk("a_rd_005", data_a, 8'h05);
    for (int k = 0; k < 16; k++) begin
      logic [10:0] r;
      r = 11'($urandom);
      addr_a = r;
      tick();
      chk("a_rd_rand", data_a, r[7:0]);
    end
    addr_a = 11'h7FF;
    tick();
    chk("a_rd_7ff", data_a, 8'hFF);

    // Read-only instance: the write must not land.
    addr_a = 11'h010; we_a = 1'b1; wdata_a = 8'hA5;
    tick();
    we_a = 1'b0;
    chk("a_ro_wr_now", data_a, 8'h10);
    tick();
    chk("a_ro_wr_next", data_a, 8'h10);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
